// File: rtl/scanline_pkg.sv
// Shared types and helpers for the scanline/mask generator.
package scanline_pkg;

  typedef enum logic {ORIENT_H, ORIENT_V} orient_t;

  localparam int unsigned SCNL_LATENCY = 3;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] width;
  } cfg_pair_t;

  // Period below 2 is meaningless for a light/dark pattern; width must leave one light step.
  function automatic cfg_pair_t clamp_cfg(input logic [31:0] period, input logic [31:0] width);
    cfg_pair_t r;
    r.period = (period < 32'd2) ? 32'd2 : period;
    r.width  = (width >= r.period) ? r.period - 32'd1 : width;
    return r;
  endfunction

endpackage

// File: rtl/scanline_atten.sv
// One colour channel of the dark-band attenuator: registered multiply by (2**LEVEL_W - level), shift.
module scanline_atten #(
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned LEVEL_W = 2
) (
  input  logic               clk_vid,
  input  logic               reset_n,
  input  logic [COLOR_W-1:0] c_i,
  input  logic [LEVEL_W-1:0] level_i,
  input  logic               dark_i,
  output logic [COLOR_W-1:0] c_o
);

  localparam int unsigned ProdW = COLOR_W + LEVEL_W + 1;

  logic [LEVEL_W:0]   gain;
  logic [ProdW-1:0]   prod;
  logic [COLOR_W-1:0] c_d, c_q;
  logic               unused_prod;

  assign gain = {1'b1, {LEVEL_W{1'b0}}} - {1'b0, level_i};
  assign prod = ProdW'(c_i) * ProdW'(gain);
  // Truncating shift: the fraction bits are dropped, and the MSB is always 0.
  assign unused_prod = ^{prod[ProdW-1], prod[LEVEL_W-1:0]};
  assign c_d = dark_i ? prod[LEVEL_W +: COLOR_W] : c_i;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      c_q <= '0;
    end else begin
      c_q <= c_d;
    end
  end

  assign c_o = c_q;

endmodule

// File: rtl/scanline_fx.sv
// Scanline/mask generator: runtime orientation, period, width and N-level attenuation, 3-cycle latency.
// Optional SCANLINE_PHASE_FLIP_EN offsets the dark band by width on alternate frames.
module scanline_fx
  import scanline_pkg::*;
#(
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned LEVEL_W = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                 clk_vid,
  input  logic                 reset_n,
  input  logic                 cfg_orient,
  input  logic [LEVEL_W-1:0]   cfg_level,
  input  logic [CNT_W-1:0]     cfg_period,
  input  logic [CNT_W-1:0]     cfg_width,
  input  logic [3*COLOR_W-1:0] core_rgb,
  input  logic                 core_hs,
  input  logic                 core_vs,
  input  logic                 core_de,
  output logic [3*COLOR_W-1:0] scnl_rgb,
  output logic                 scnl_hs,
  output logic                 scnl_vs,
  output logic                 scnl_de
);

  logic hs_q, vs_q, hs_fall, vs_fall;

  orient_t            orient_q, orient_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   period_q, period_d, width_q, width_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, clr_val;
  logic               cnt_inc, cnt_clr;
  cfg_pair_t          cfg_clamped;

  logic [3*COLOR_W-1:0] rgb_s1_q, rgb_s2, rgb_s3_q;
  logic [LEVEL_W-1:0]   level_s1_q;
  logic                 dark_d, dark_s1_q;

  logic [SCNL_LATENCY-1:0] hs_dly_q, vs_dly_q, de_dly_q;

  assign hs_fall = hs_q & ~core_hs;
  assign vs_fall = vs_q & ~core_vs;

  assign cfg_clamped = clamp_cfg(32'(cfg_period), 32'(cfg_width));

  // Shadow config only moves at the frame boundary so a frame never mixes settings.
  always_comb begin
    orient_d = orient_q;
    level_d  = level_q;
    period_d = period_q;
    width_d  = width_q;
    if (vs_fall) begin
      orient_d = orient_t'(cfg_orient);
      level_d  = cfg_level;
      period_d = CNT_W'(cfg_clamped.period);
      width_d  = CNT_W'(cfg_clamped.width);
    end
  end

`ifdef SCANLINE_PHASE_FLIP_EN
  logic flip_q, flip_d;

  assign flip_d  = flip_q ^ vs_fall;
  assign clr_val = flip_d ? width_d : '0;

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      flip_q <= 1'b0;
    end else begin
      flip_q <= flip_d;
    end
  end
`else
  assign clr_val = '0;
`endif

  always_comb begin
    if (orient_q == ORIENT_H) begin
      cnt_inc = hs_fall;
      cnt_clr = vs_fall;
    end else begin
      cnt_inc = core_de;
      cnt_clr = hs_fall;
    end
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = clr_val;
    end else if (cnt_inc) begin
      cnt_d = (cnt_q >= period_q - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign dark_d = (cnt_q < width_q) && (level_q != '0);

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      orient_q   <= ORIENT_H;
      level_q    <= '0;
      period_q   <= '0;
      width_q    <= '0;
      cnt_q      <= '0;
      rgb_s1_q   <= '0;
      level_s1_q <= '0;
      dark_s1_q  <= 1'b0;
      rgb_s3_q   <= '0;
      hs_dly_q   <= '0;
      vs_dly_q   <= '0;
      de_dly_q   <= '0;
    end else begin
      hs_q       <= core_hs;
      vs_q       <= core_vs;
      orient_q   <= orient_d;
      level_q    <= level_d;
      period_q   <= period_d;
      width_q    <= width_d;
      cnt_q      <= cnt_d;
      rgb_s1_q   <= core_rgb;
      level_s1_q <= level_q;
      dark_s1_q  <= dark_d;
      rgb_s3_q   <= rgb_s2;
      hs_dly_q   <= {hs_dly_q[SCNL_LATENCY-2:0], core_hs};
      vs_dly_q   <= {vs_dly_q[SCNL_LATENCY-2:0], core_vs};
      de_dly_q   <= {de_dly_q[SCNL_LATENCY-2:0], core_de};
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    scanline_atten #(
      .COLOR_W(COLOR_W),
      .LEVEL_W(LEVEL_W)
    ) u_atten (
      .clk_vid(clk_vid),
      .reset_n(reset_n),
      .c_i    (rgb_s1_q[ch*COLOR_W +: COLOR_W]),
      .level_i(level_s1_q),
      .dark_i (dark_s1_q),
      .c_o    (rgb_s2[ch*COLOR_W +: COLOR_W])
    );
  end

  assign scnl_rgb = rgb_s3_q;
  assign scnl_hs  = hs_dly_q[SCNL_LATENCY-1];
  assign scnl_vs  = vs_dly_q[SCNL_LATENCY-1];
  assign scnl_de  = de_dly_q[SCNL_LATENCY-1];

endmodule

// File: tb/tb_scanline_fx.sv
// Directed bench for scanline_fx: expected pixels come from a line/pixel-index band model.
module tb_scanline_fx;

  logic        clk_vid = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_orient = 1'b0;
  logic [1:0]  cfg_level = 2'd0;
  logic [3:0]  cfg_period = 4'd0;
  logic [3:0]  cfg_width = 4'd0;
  logic [23:0] core_rgb = 24'd0;
  logic        core_hs = 1'b0;
  logic        core_vs = 1'b0;
  logic        core_de = 1'b0;
  logic [23:0] scnl_rgb;
  logic        scnl_hs, scnl_vs, scnl_de;

  int          checks = 0;
  int          errors = 0;
  logic [26:0] exp_q[$];
  logic        prev_vs = 1'b0;
  logic        mdl_flip = 1'b0;

  always #5 clk_vid = ~clk_vid;

  scanline_fx #(
    .COLOR_W(8),
    .LEVEL_W(2),
    .CNT_W  (4)
  ) dut (
    .clk_vid   (clk_vid),
    .reset_n   (reset_n),
    .cfg_orient(cfg_orient),
    .cfg_level (cfg_level),
    .cfg_period(cfg_period),
    .cfg_width (cfg_width),
    .core_rgb  (core_rgb),
    .core_hs   (core_hs),
    .core_vs   (core_vs),
    .core_de   (core_de),
    .scnl_rgb  (scnl_rgb),
    .scnl_hs   (scnl_hs),
    .scnl_vs   (scnl_vs),
    .scnl_de   (scnl_de)
  );

  function automatic logic [23:0] dim(input int level);
    case (level)
      1:       return 24'hBFBFBF;
      2:       return 24'h7F7F7F;
      3:       return 24'h3F3F3F;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  // Drive one cycle; returns the output and the value expected for the input 3 cycles back.
  task automatic drive(input logic [23:0] rgb, input logic hs, input logic vs, input logic de,
                       input logic [23:0] erg, output logic v, output logic [26:0] obs,
                       output logic [26:0] ex);
    core_rgb = rgb;
    core_hs  = hs;
    core_vs  = vs;
    core_de  = de;
`ifdef SCANLINE_PHASE_FLIP_EN
    if (prev_vs && !vs) mdl_flip = ~mdl_flip;
`endif
    prev_vs = vs;
    exp_q.push_back({erg, hs, vs, de});
    @(posedge clk_vid);
    #1;
    obs = {scnl_rgb, scnl_hs, scnl_vs, scnl_de};
    v   = 1'b0;
    ex  = '0;
    if (exp_q.size() == 3) begin
      ex = exp_q.pop_front();
      v  = 1'b1;
    end
  endtask

  // vs+hs pulse falling together, then lines of white pixels each followed by an hs pulse.
  task automatic frame(input string nm, input logic orient, input logic [3:0] period,
                       input logic [3:0] width, input logic [1:0] level, input int nlines,
                       input int npix, input int ep, input int ew, input int el, input int chg);
    logic v, hs, vs, de, dk;
    logic [26:0] o, e;
    logic [23:0] rgb, erg;
    int l, p, idx;
    cfg_orient = orient;
    cfg_period = period;
    cfg_width  = width;
    cfg_level  = level;
    for (int c = 0; c < 2 + nlines * (npix + 4); c++) begin
      if (c < 2) begin
        hs = 1'b1; vs = 1'b1; de = 1'b0; rgb = '0; erg = '0;
      end else begin
        l = (c - 2) / (npix + 4);
        p = (c - 2) % (npix + 4) - 1;
        if (l == 1 && chg >= 0) cfg_level = 2'(chg);
        hs  = (p >= npix + 1);
        vs  = 1'b0;
        de  = (p >= 0) && (p < npix);
        rgb = de ? 24'hFFFFFF : 24'h0;
        idx = (orient ? p : l) + (mdl_flip ? ew : 0);
        dk  = (el != 0) && ((idx % ep) < ew);
        erg = !de ? 24'h0 : (dk ? dim(el) : 24'hFFFFFF);
      end
      drive(rgb, hs, vs, de, erg, v, o, e);
      if (v) begin
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL %s cyc%0d: got %h expected %h", nm, c, o, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    core_rgb = 24'hFFFFFF; core_hs = 1'b1; core_vs = 1'b1; core_de = 1'b1;
    repeat (3) @(posedge clk_vid);
    #1;
    checks++;
    if ({scnl_rgb, scnl_hs, scnl_vs, scnl_de} !== 27'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", {scnl_rgb, scnl_hs, scnl_vs, scnl_de});
    end
    core_rgb = '0; core_hs = 1'b0; core_vs = 1'b0; core_de = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(posedge clk_vid);
    #1;
    checks++;
    if ({scnl_rgb, scnl_hs, scnl_vs, scnl_de} !== 27'd0) begin
      errors++;
      $display("FAIL reset_release: got %h expected 0", {scnl_rgb, scnl_hs, scnl_vs, scnl_de});
    end
  endtask

  task automatic test_bypass();
    logic v;
    logic [26:0] o, e;
    logic [23:0] rgb;
    cfg_level = 2'd0; cfg_period = 4'd2; cfg_width = 4'd1;
    for (int i = 0; i < 24; i++) begin
      rgb = {8'(i), 8'(i * 3), 8'(255 - i)};
      drive(rgb, (i % 7) >= 5, (i >= 12) && (i < 15), (i % 4) != 0, rgb, v, o, e);
      if (v) begin
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL bypass i%0d: got %h expected %h", i, o, e);
        end
      end
    end
  endtask

  task automatic test_hmode();
    frame("h_frame0", 1'b0, 4'd2, 4'd1, 2'd2, 3, 4, 2, 1, 2, -1);
    frame("h_frame1", 1'b0, 4'd2, 4'd1, 2'd2, 3, 4, 2, 1, 2, -1);
  endtask

  task automatic test_vmode();
    frame("v_frame", 1'b1, 4'd4, 4'd1, 2'd3, 2, 10, 4, 1, 3, -1);
  endtask

  task automatic test_level_change();
    frame("lvl_keep", 1'b0, 4'd2, 4'd1, 2'd1, 3, 4, 2, 1, 1, 3);
    frame("lvl_next", 1'b0, 4'd2, 4'd1, 2'd3, 2, 4, 2, 1, 3, -1);
  endtask

  task automatic test_clamp();
    frame("clamp_h", 1'b0, 4'd0, 4'd7, 2'd2, 4, 3, 2, 1, 2, -1);
    frame("clamp_v", 1'b1, 4'd1, 4'd9, 2'd1, 1, 6, 2, 1, 1, -1);
  endtask

  task automatic test_reset_mid();
    logic v, de, dk;
    logic [26:0] o, e;
    logic [23:0] erg;
    frame("pre_rst", 1'b0, 4'd2, 4'd1, 2'd2, 2, 4, 2, 1, 2, -1);
    // Third line of that frame, cut short by reset.
    for (int p = -1; p < 5; p++) begin
      de  = (p >= 0);
      dk  = (((2 + (mdl_flip ? 1 : 0)) % 2) < 1);
      erg = !de ? 24'h0 : (dk ? 24'h7F7F7F : 24'hFFFFFF);
      drive(de ? 24'hFFFFFF : 24'h0, 1'b0, 1'b0, de, erg, v, o, e);
      if (v) begin
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL pre_rst_line p%0d: got %h expected %h", p, o, e);
        end
      end
    end
    checks++;
    if (scnl_de !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_de: got %b expected 1", scnl_de);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({scnl_rgb, scnl_hs, scnl_vs, scnl_de} !== 27'd0) begin
      errors++;
      $display("FAIL async_rst: got %h expected 0", {scnl_rgb, scnl_hs, scnl_vs, scnl_de});
    end
    exp_q.delete();
    prev_vs  = 1'b0;
    mdl_flip = 1'b0;
    core_rgb = '0; core_de = 1'b0;
    @(posedge clk_vid);
    #1;
    reset_n = 1'b1;
    // cfg_level is still 2, but nothing is loaded until a vs fall.
    for (int p = -1; p < 11; p++) begin
      de = (p >= 0) && (p < 8);
      drive(de ? 24'hFFFFFF : 24'h0, p >= 9, 1'b0, de, de ? 24'hFFFFFF : 24'h0, v, o, e);
      if (v) begin
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL post_rst_bypass p%0d: got %h expected %h", p, o, e);
        end
      end
    end
    frame("post_rst0", 1'b0, 4'd2, 4'd1, 2'd2, 2, 4, 2, 1, 2, -1);
    frame("post_rst1", 1'b0, 4'd2, 4'd1, 2'd2, 2, 4, 2, 1, 2, -1);
    for (int i = 0; i < 3; i++) begin
      drive(24'h0, 1'b0, 1'b0, 1'b0, 24'h0, v, o, e);
      if (v) begin
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL drain i%0d: got %h expected %h", i, o, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_hmode();
    test_vmode();
    test_level_change();
    test_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
